i2c_slave_responder: RTL and testbench

I2C slave (target) endpoint that answers a single 7-bit device address on the same two-wire bus our I2C master transceiver drives. It lives in the audio/video configuration path as a bus-functional codec stand-in and as a register-access port for on-chip configuration logic. It detects START, repeated START and STOP, receives and ACKs the address byte, delivers write bytes to local logic, and serves read bytes from local logic through a request strobe.

---
 rtl/i2c_slave_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_responder
// Brief    : I2C target endpoint answering one 7-bit address. Detects START,
//            repeated START and STOP, ACKs its address, hands write bytes to
//            local logic and serves read bytes via a request strobe.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_responder #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h1A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdata,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_request,
    output logic       stop_detected,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_BYTE  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_BYTE  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    // Synchronizer and edge-history registers (idle bus level is high)
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    // Protocol state
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       first_q, first_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       tx_request_q, tx_request_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;

    // Decoded bus events from the synchronized copies
    logic scl_rise, scl_fall, start_cond, stop_cond;

    assign scl_rise   =  scl_sync_q & ~scl_prev_q;
    assign scl_fall   = ~scl_sync_q &  scl_prev_q;
    // Any SDA edge while SCL is high is a bus condition, never data
    assign start_cond =  scl_sync_q & ~sda_sync_q &  sda_prev_q;
    assign stop_cond  =  scl_sync_q &  sda_sync_q & ~sda_prev_q;

    // Open-drain pad: only ever pull low or release
    assign i2c_sdata = sda_oe_q ? 1'b0 : 1'bz;

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_first      = rx_first_q;
    assign tx_request    = tx_request_q;
    assign stop_detected = stop_q;
    assign busy          = busy_q;

    // Two-flop synchronizers plus a previous-value stage for edge decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= i2c_sclk;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= i2c_sdata;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    // Protocol state register; reset releases SDA immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            shift_q      <= 8'h00;
            rw_q         <= 1'b0;
            first_q      <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            tx_request_q <= 1'b0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            first_q      <= first_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_first_q   <= rx_first_d;
            tx_request_q <= tx_request_d;
            stop_q       <= stop_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic: STOP/START first, then per-state bit handling
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        first_d      = first_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_first_d   = 1'b0;
        tx_request_d = 1'b0;
        stop_d       = 1'b0;
        busy_d       = busy_q;

        if (stop_cond) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            stop_d   = 1'b1;
            busy_d   = 1'b0;
        end else if (start_cond) begin
            state_d  = S_ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_sync_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (shift_q[7:1] == DEVICE_ADDRESS) begin
                            state_d  = S_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            rw_d     = shift_q[0];
                            busy_d   = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_rise && rw_q) begin
                        tx_request_d = 1'b1;
                    end
                    if (scl_fall) begin
                        if (rw_q) begin
                            // First read bit goes out on the fall ending the ACK slot
                            state_d  = S_RD_BYTE;
                            sda_oe_d = ~tx_data[7];
                            shift_d  = {tx_data[6:0], 1'b0};
                            cnt_d    = 4'd1;
                        end else begin
                            state_d  = S_WR_BYTE;
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            first_d  = 1'b1;
                        end
                    end
                end
                S_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_sync_q};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_sync_q};
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                            state_d    = S_WR_ACK;
                        end
                    end
                end
                S_WR_ACK: begin
                    // Count 8 = waiting for 8th fall, 9 = waiting for 9th fall
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b1;
                            cnt_d    = 4'd9;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = S_WR_BYTE;
                        end
                    end
                end
                S_RD_BYTE: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RD_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_sync_q) begin
                            tx_request_d = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall) begin
                        // Only reachable after the master ACKed
                        state_d  = S_RD_BYTE;
                        sda_oe_d = ~tx_data[7];
                        shift_d  = {tx_data[6:0], 1'b0};
                        cnt_d    = 4'd1;
                    end
                end
                S_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_responder
// Brief    : Self-checking bench: bus-functional I2C master with jittered SDA,
//            transaction-level expectation model and event monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_responder;

    localparam logic [6:0] C_DEV_ADDR = 7'h1A;

    logic       clk;
    logic       reset;
    logic       scl;
    logic       m_sda;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       tx_request;
    logic       stop_detected;
    logic       busy;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda ? 1'bz : 1'b0;

    i2c_slave_responder #(.DEVICE_ADDRESS(C_DEV_ADDR)) dut (
        .clk          (clk),
        .reset        (reset),
        .i2c_sclk     (scl),
        .i2c_sdata    (sda_bus),
        .tx_data      (tx_data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_first     (rx_first),
        .tx_request   (tx_request),
        .stop_detected(stop_detected),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Observed events
    logic [8:0] rx_got[$];
    int         req_cnt  = 0;
    int         stop_cnt = 0;
    // Expectations
    logic [8:0] rx_exp[$];
    int         exp_req  = 0;
    int         exp_stop = 0;
    // Bytes local logic will hand out on successive read requests
    logic [7:0] tx_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] last_wr = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: record pulses and serve read data on request
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid) rx_got.push_back({rx_first, rx_data});
            if (stop_detected) stop_cnt++;
            if (tx_request) begin
                req_cnt++;
                if (tx_q.size() > 0) tx_data = tx_q.pop_front();
                else tx_data = 8'($urandom);
            end
        end
    end

    // One SCL period; SDA changes at a random point of the low phase
    task automatic bus_bit(input logic d, output logic s);
        int j;
        j = $urandom_range(10, 80);
        #(j);
        m_sda = d;
        #(100 - j);
        scl = 1'b1;
        #50;
        s = sda_bus;
        #50;
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_lvl);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, ack_lvl);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            b = {b[6:0], s};
        end
        bus_bit(nack, s);
    endtask

    task automatic bus_start();
        #50 m_sda = 1'b0;
        #50 scl = 1'b0;
    endtask

    task automatic bus_rep_start();
        #30 m_sda = 1'b1;
        #70 scl = 1'b1;
        #50 m_sda = 1'b0;
        #50 scl = 1'b0;
    endtask

    task automatic bus_stop();
        #25 m_sda = 1'b0;
        #75 scl = 1'b1;
        #50 m_sda = 1'b1;
        #50;
    endtask

    task automatic check_after_stop(input string tag);
        int n;
        repeat (8) @(posedge clk);
        #1;
        chk({tag, "_stop_cnt"}, 32'(stop_cnt), 32'(exp_stop));
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_req_cnt"}, 32'(req_cnt), 32'(exp_req));
        chk({tag, "_rx_cnt"}, 32'(rx_got.size()), 32'(rx_exp.size()));
        n = (rx_got.size() < rx_exp.size()) ? rx_got.size() : rx_exp.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_rx_byte"}, {23'd0, rx_got[i]}, {23'd0, rx_exp[i]});
        chk({tag, "_rx_hold"}, {24'd0, rx_data}, {24'd0, last_wr});
        rx_got.delete();
        rx_exp.delete();
    endtask

    // One addressed transfer using pay_q as write data or expected read data
    task automatic do_txn(input logic [6:0] addr, input logic rw, input bit rep, input bit do_stop);
        logic       ack;
        logic       match;
        logic [7:0] b;
        int         n;
        match = (addr == C_DEV_ADDR);
        n     = pay_q.size();
        tx_q.delete();
        if (rw) begin
            foreach (pay_q[i]) tx_q.push_back(pay_q[i]);
        end
        if (rep) bus_rep_start();
        else bus_start();
        send_byte({addr, rw}, ack);
        chk("addr_ack", {31'd0, ack}, {31'd0, ~match});
        #1;
        chk("busy_match", {31'd0, busy}, {31'd0, match});
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                send_byte(pay_q[i], ack);
                chk("wr_ack", {31'd0, ack}, {31'd0, ~match});
                if (match) begin
                    rx_exp.push_back({(i == 0), pay_q[i]});
                    last_wr = pay_q[i];
                end
            end else begin
                read_byte((i == n - 1), b);
                chk("rd_byte", {24'd0, b}, match ? {24'd0, pay_q[i]} : 32'hFF);
            end
        end
        if (rw && match) exp_req += n;
        if (do_stop) begin
            bus_stop();
            exp_stop++;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       s;
        reset   = 1'b1;
        scl     = 1'b1;
        m_sda   = 1'b1;
        tx_data = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_flags", {27'd0, rx_valid, rx_first, tx_request, stop_detected, busy}, 32'd0);
        chk("rst_sda", {31'd0, sda_bus}, 32'd1);
        #2 reset = 1'b0;
        repeat (4) @(posedge clk);

        // Write 0x0C, 0x5A
        pay_q = '{8'h0C, 8'h5A};
        do_txn(C_DEV_ADDR, 1'b0, 1'b0, 1'b1);
        check_after_stop("wr2");

        // Address mismatch then one byte
        pay_q = '{8'h77};
        do_txn(7'h1B, 1'b0, 1'b0, 1'b1);
        check_after_stop("mismatch");

        // Read 0xA5 (ACK) then 0x3C (NACK)
        pay_q = '{8'hA5, 8'h3C};
        do_txn(C_DEV_ADDR, 1'b1, 1'b0, 1'b1);
        check_after_stop("rd2");

        // Register index write, repeated START, one-byte read
        pay_q = '{8'h02};
        do_txn(C_DEV_ADDR, 1'b0, 1'b0, 1'b0);
        pay_q = '{8'h96};
        do_txn(C_DEV_ADDR, 1'b1, 1'b1, 1'b1);
        check_after_stop("rep_start");

        // Reset while the address ACK holds SDA low
        bus_start();
        b = 8'h34;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        #60 m_sda = 1'b1;
        #1;
        chk("ack_held_low", {31'd0, sda_bus}, 32'd0);
        #39 scl = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_sda", {31'd0, sda_bus}, 32'd1);
        chk("async_rst_rx", {24'd0, rx_data}, 32'd0);
        chk("async_rst_flags", {27'd0, rx_valid, rx_first, tx_request, stop_detected, busy}, 32'd0);
        last_wr = 8'h00;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #40 scl = 1'b0;
        bus_stop();
        exp_stop++;
        check_after_stop("post_rst");
        pay_q = '{8'hC3};
        do_txn(C_DEV_ADDR, 1'b0, 1'b0, 1'b1);
        check_after_stop("after_rst");

        // Randomized traffic
        for (int t = 0; t < 16; t++) begin
            logic [6:0] a;
            int         len;
            a   = ($urandom_range(0, 4) == 0) ? 7'($urandom) : C_DEV_ADDR;
            len = $urandom_range(1, 4);
            pay_q.delete();
            for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                do_txn(a, 1'b0, 1'b0, 1'b0);
                pay_q.delete();
                for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
                do_txn(a, 1'b1, 1'b1, 1'b1);
            end else begin
                do_txn(a, 1'($urandom), 1'b0, 1'b1);
            end
            check_after_stop("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
